// File: rtl/jam_param.sv
// jam_param: brute-force N x N job-assignment engine sweeping all permutations in lexicographic
// order. Define JAM_PRUNE_EN to abandon an assignment once its partial sum exceeds MinCost.
module jam_param #(
  parameter int unsigned N   = 8,
  parameter int unsigned CW  = 7,
  parameter int unsigned IW  = 3,
  parameter int unsigned SW  = 10,
  parameter int unsigned MCW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic           busy,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic [SW-1:0]  MinCost,
  output logic [MCW-1:0] MatchCount,
  output logic           Valid
);

  typedef enum logic [2:0] {StIdle, StLoad, StCmp, StPerm, StDone} state_e;

  state_e        state;
  logic [IW-1:0] k;
  logic [IW-1:0] perm     [N];
  logic [IW-1:0] perm_swp [N];
  logic [IW-1:0] perm_nxt [N];
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_add;
  logic [IW-1:0] piv;
  logic [IW-1:0] succ;
  logic [IW-1:0] rev;
  logic          has_piv;
  logic          cmp_en;

`ifdef JAM_PRUNE_EN
  logic pruned;
  assign cmp_en = !pruned;
`else
  assign cmp_en = 1'b1;
`endif

  assign sum_add = sum + SW'(Cost);
  assign W       = (state == StLoad) ? k : '0;
  assign J       = (state == StLoad) ? perm[k] : '0;

  // Next lexicographic permutation; has_piv low means perm is strictly descending (last one).
  always_comb begin
    has_piv = 1'b0;
    piv     = '0;
    succ    = '0;
    rev     = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        has_piv = 1'b1;
        piv     = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (IW'(i) > piv && perm[i] > perm[piv]) succ = IW'(i);
    end
    perm_swp       = perm;
    perm_swp[piv]  = perm[succ];
    perm_swp[succ] = perm[piv];
    perm_nxt       = perm_swp;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) > piv) begin
        // Mirror index within perm[piv+1..N-1]; modular IW-bit math is exact here.
        rev         = piv + IW'(N) - IW'(i);
        perm_nxt[i] = perm_swp[rev];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= StIdle;
      k          <= '0;
      sum        <= '0;
      MinCost    <= '1;
      MatchCount <= '0;
      Valid      <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
`ifdef JAM_PRUNE_EN
      pruned     <= 1'b0;
`endif
    end else begin
      Valid <= 1'b0;
      unique case (state)
        StIdle: begin
          for (int i = 0; i < N; i++) perm[i] <= IW'(i);
          sum <= '0;
          k   <= '0;
          if (start) begin
            state      <= StLoad;
            busy       <= 1'b1;
            MinCost    <= '1;
            MatchCount <= '0;
          end
        end
        StLoad: begin
          sum <= sum_add;
          k   <= k + 1'b1;
          if (k == IW'(N - 1)) begin
            state <= StCmp;
            k     <= '0;
          end
`ifdef JAM_PRUNE_EN
          else if (sum_add > MinCost) begin
            state  <= StCmp;
            k      <= '0;
            pruned <= 1'b1;
          end
`endif
        end
        StCmp: begin
          if (cmp_en && sum < MinCost) begin
            MinCost    <= sum;
            MatchCount <= MCW'(1);
          end else if (cmp_en && sum == MinCost && MatchCount != '1) begin
            MatchCount <= MatchCount + 1'b1;
          end
          sum <= '0;
`ifdef JAM_PRUNE_EN
          pruned <= 1'b0;
`endif
          if (has_piv) begin
            state <= StPerm;
          end else begin
            state <= StDone;
            Valid <= 1'b1;
          end
        end
        StPerm: begin
          perm  <= perm_nxt;
          state <= StLoad;
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_param.sv
// tb_jam_param: drives several jam_param configurations from a shared cost table and checks
// results against an exhaustive tuple-scan model of the assignment problem.
module tb_jam_param;

  localparam int NI = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [6:0] tab [8][8];
  logic       start_v [NI];
  int         sel;
  int         n_checks = 0;
  int         n_errors = 0;

  int p_n   [NI] = '{3, 4, 4, 6};
  int p_mcw [NI] = '{4, 5, 4, 10};
  int p_sw  [NI] = '{9, 9, 9, 10};

  logic       b0, v0, b1, v1, b2, v2, b3, v3;
  logic [1:0] w0, j0, w1, j1, w2, j2;
  logic [2:0] w3, j3;
  logic [6:0] c0, c1, c2, c3;
  logic [8:0] m0, m1, m2;
  logic [9:0] m3;
  logic [3:0] k0, k2;
  logic [4:0] k1;
  logic [9:0] k3;

  assign c0 = tab[int'(w0)][int'(j0)];
  assign c1 = tab[int'(w1)][int'(j1)];
  assign c2 = tab[int'(w2)][int'(j2)];
  assign c3 = tab[int'(w3)][int'(j3)];

  jam_param #(.N(3), .CW(7), .IW(2), .SW(9), .MCW(4)) u_n3 (
    .CLK(CLK), .RST(RST), .start(start_v[0]), .busy(b0), .W(w0), .J(j0), .Cost(c0),
    .MinCost(m0), .MatchCount(k0), .Valid(v0));
  jam_param #(.N(4), .CW(7), .IW(2), .SW(9), .MCW(5)) u_n4w (
    .CLK(CLK), .RST(RST), .start(start_v[1]), .busy(b1), .W(w1), .J(j1), .Cost(c1),
    .MinCost(m1), .MatchCount(k1), .Valid(v1));
  jam_param #(.N(4), .CW(7), .IW(2), .SW(9), .MCW(4)) u_n4 (
    .CLK(CLK), .RST(RST), .start(start_v[2]), .busy(b2), .W(w2), .J(j2), .Cost(c2),
    .MinCost(m2), .MatchCount(k2), .Valid(v2));
  jam_param #(.N(6), .CW(7), .IW(3), .SW(10), .MCW(10)) u_n6 (
    .CLK(CLK), .RST(RST), .start(start_v[3]), .busy(b3), .W(w3), .J(j3), .Cost(c3),
    .MinCost(m3), .MatchCount(k3), .Valid(v3));

  int o_busy, o_valid, o_w, o_j, o_min, o_cnt;
  always_comb begin
    o_busy = 0; o_valid = 0; o_w = 0; o_j = 0; o_min = 0; o_cnt = 0;
    case (sel)
      0: begin o_busy = b0; o_valid = v0; o_w = w0; o_j = j0; o_min = m0; o_cnt = k0; end
      1: begin o_busy = b1; o_valid = v1; o_w = w1; o_j = j1; o_min = m1; o_cnt = k1; end
      2: begin o_busy = b2; o_valid = v2; o_w = w2; o_j = j2; o_min = m2; o_cnt = k2; end
      3: begin o_busy = b3; o_valid = v3; o_w = w3; o_j = j3; o_min = m3; o_cnt = k3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f *= i;
    return f;
  endfunction

  // Scan every worker->job tuple, keep those that use each job once, track min and tie count.
  function automatic void model(input int n, input int mcw, output int mn, output int cnt);
    int total, lim, x, used, s, jj;
    bit ok;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    lim = (1 << mcw) - 1;
    mn  = 1 << 30;
    cnt = 0;
    for (int m = 0; m < total; m++) begin
      x = m; used = 0; s = 0; ok = 1'b1;
      for (int w = 0; w < n; w++) begin
        jj = x % n;
        x  = x / n;
        if (used[jj]) ok = 1'b0;
        used = used | (1 << jj);
        s += int'(tab[w][jj]);
      end
      if (ok) begin
        if (s < mn) begin
          mn  = s;
          cnt = 1;
        end else if (s == mn && cnt < lim) begin
          cnt++;
        end
      end
    end
  endfunction

  int wq[$];
  int jq[$];
  int last_cyc, last_min, last_cnt;

  task automatic run_job(input int s, input string tag, input int mid);
    int n, mn, cnt, exp_cyc, cyc;
    n = p_n[s];
    model(n, p_mcw[s], mn, cnt);
    exp_cyc = fact(n) * (n + 2) - 1;
    sel = s;
    wq.delete();
    jq.delete();
    @(negedge CLK);
    start_v[s] = 1'b1;
    @(negedge CLK);
    start_v[s] = 1'b0;
    cyc = 0;
    check({tag, "_busy_start"}, o_busy, 1);
    while (o_valid == 0 && cyc <= exp_cyc + 4) begin
      wq.push_back(o_w);
      jq.push_back(o_j);
      start_v[s] = (cyc == mid);
      @(negedge CLK);
      cyc++;
    end
    start_v[s] = 1'b0;
    last_cyc = cyc;
    check({tag, "_valid_seen"}, o_valid, 1);
`ifdef JAM_PRUNE_EN
    check({tag, "_cycle_le"}, int'(cyc <= exp_cyc), 1);
`else
    check({tag, "_cycle"}, cyc, exp_cyc);
`endif
    check({tag, "_min"}, o_min, mn);
    check({tag, "_cnt"}, o_cnt, cnt);
    check({tag, "_busy_at_valid"}, o_busy, 1);
    last_min = o_min;
    last_cnt = o_cnt;
    @(negedge CLK);
    check({tag, "_valid_drop"}, o_valid, 0);
    check({tag, "_busy_drop"}, o_busy, 0);
    repeat (3) @(negedge CLK);
    check({tag, "_min_hold"}, o_min, mn);
    check({tag, "_cnt_hold"}, o_cnt, cnt);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) tab[w][j] = 7'($urandom_range(hi, lo));
  endtask

  task automatic check_reset_state(input string tag, input int s);
    sel = s;
    #1;
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_min"}, o_min, (1 << p_sw[s]) - 1);
    check({tag, "_cnt"}, o_cnt, 0);
    check({tag, "_w"}, o_w, 0);
    check({tag, "_j"}, o_j, 0);
  endtask

  initial begin
    RST = 1'b1;
    sel = 0;
    for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) tab[w][j] = (w == j) ? 7'd0 : 7'd10;
    repeat (3) @(negedge CLK);
    check_reset_state("rst_n3", 0);
    check_reset_state("rst_n6", 3);
    @(negedge CLK);
    RST = 1'b0;

    // N=3 diagonal table: single zero-cost assignment.
    run_job(0, "n3diag", -1);
    check("n3diag_spec_min", last_min, 0);
    check("n3diag_spec_cnt", last_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n3diag_first_w%0d", i), wq[i], i);
      check($sformatf("n3diag_first_j%0d", i), jq[i], i);
    end
`ifndef JAM_PRUNE_EN
    for (int i = 0; i < 3; i++) begin
      check($sformatf("n3diag_last_w%0d", i), wq[last_cyc - 4 + i], i);
      check($sformatf("n3diag_last_j%0d", i), jq[last_cyc - 4 + i], 2 - i);
    end
`endif

    // N=4, Cost=W+J: every assignment totals 12.
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) tab[w][j] = 7'(w + j);
    run_job(1, "n4sum_mcw5", -1);
    check("n4sum_mcw5_spec_cnt", last_cnt, 24);
    run_job(2, "n4sum_mcw4", -1);
    check("n4sum_mcw4_spec_min", last_min, 12);
    check("n4sum_mcw4_spec_sat", last_cnt, 15);

    // N=6 analogue of the single-pair table: 7 everywhere, zero at (3,5) and (5,3).
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) tab[w][j] = 7'd7;
    tab[3][5] = 7'd0;
    tab[5][3] = 7'd0;
    run_job(3, "n6pair", -1);
    check("n6pair_spec_min", last_min, 28);
    check("n6pair_spec_cnt", last_cnt, 24);
`ifdef JAM_PRUNE_EN
    check("n6pair_pruned_earlier", int'(last_cyc < fact(6) * 8 - 1), 1);
`endif

    // Reruns with fresh random tables: no carry-over, mid-run start ignored.
    fill_random(1, 3);
    run_job(0, "n3rand", -1);
    fill_random(0, 3);
    run_job(2, "n4rand_mid", 50);
    fill_random(0, 2);
    run_job(1, "n4rand_mid2", 7);
    fill_random(0, 5);
    run_job(3, "n6rand", 1000);

    // Asynchronous reset between edges in cycle 100 of a run, then a clean run.
    fill_random(0, 3);
    sel = 2;
    @(negedge CLK);
    start_v[2] = 1'b1;
    @(negedge CLK);
    start_v[2] = 1'b0;
    repeat (100) @(negedge CLK);
    check("midrst_busy_before", o_busy, 1);
    #1 RST = 1'b1;
    check_reset_state("midrst", 2);
    @(negedge CLK);
    check("midrst_no_valid", o_valid, 0);
    RST = 1'b0;
    run_job(2, "after_rst", -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised brute-force job-assignment engine: N workers, N jobs, one cost lookup per cycle.
- Enumerates all N! assignments in lexicographic order and accumulates the cost of each.
- Reports the minimum total cost and how many assignments reach it.
- Successor to the fixed 8x8 engine: adds parametrised N and widths, a start/busy handshake, re-runnable operation, a saturating match counter and an optional pruning mode.

Parameters:
N, 8, number of workers = number of jobs (2..8)
CW, 7, Cost width in bits
IW, 3, W/J index width, must satisfy 2^IW >= N
SW, 10, sum/MinCost width = CW + ceil(log2 N)
MCW, 4, MatchCount width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  run request, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until Valid falls
W  out  IW  worker index of the current lookup
J  out  IW  job index of the current lookup
Cost  in  CW  cost of (W,J); combinational response in the same cycle
MinCost  out  SW  minimum total cost found
MatchCount  out  MCW  number of assignments equal to MinCost, saturating
Valid  out  1  one-cycle pulse: MinCost/MatchCount are final

Behaviour:
- Reset (async, RST=1): state=IDLE; perm[i]=i; sum=0; MinCost=all ones; MatchCount=0; Valid=0; busy=0; W=J=0.
- FSM states and transitions:
  - IDLE: on start=1 -> LOAD. Also performs: perm<=identity, sum<=0, MinCost<=all ones, MatchCount<=0.
  - LOAD: lasts N cycles, counter k=0..N-1.
    - W=k, J=perm[k]; sum<=sum+Cost each cycle.
    - After k=N-1 -> CMP.
  - CMP, one cycle:
    - sum<MinCost: MinCost<=sum, MatchCount<=1.
    - sum==MinCost: MatchCount<=MatchCount+1, saturating at 2^MCW-1.
    - else: hold.
    - Clear sum. If perm is strictly descending -> DONE, else -> PERM.
  - PERM, one cycle, combinational next-permutation:
    - pivot p = largest i with perm[i]<perm[i+1].
    - q = largest i>p with perm[i]>perm[p].
    - Swap perm[p] and perm[q], then reverse perm[p+1..N-1]. All written in the same edge.
    - -> LOAD.
  - DONE: Valid=1 for this cycle only -> IDLE.
- W=J=0 in every state except LOAD. Cost is ignored outside LOAD.
- sum is SW bits. N*(2^CW-1) < 2^SW-1, so no overflow and no false tie with the initial MinCost.
- Latency: each assignment takes N+2 cycles. With the first cycle after the start edge counted as 0, Valid is high in cycle N!*(N+2)-1.
  - N=3: cycle 29.
  - N=8: cycle 403199.
- MinCost and MatchCount hold their values after DONE until the next accepted start.
- start while busy: ignored, no restart, no effect on results.
- RST mid-run: immediate abort to reset values. No Valid pulse.

Optional Feature:
- Macro: JAM_PRUNE_EN.
- Defined:
  - In LOAD, if sum+Cost > MinCost (strict), skip the remaining lookups and go to CMP next cycle. CMP then makes no update.
  - Equal partial sums are never pruned, so ties are still counted.
  - Final MinCost and MatchCount are identical to the unpruned run. Valid arrives no later than the unpruned cycle.
- Undefined: every assignment takes exactly N full lookups; latency is as stated above.

Test Plan:
- N=3, Cost = (W==J)?0:10; start pulse -> Valid in cycle 29, MinCost=0, MatchCount=1; W/J sequence of the first assignment (0,0),(1,1),(2,2), of the last (0,2),(1,1),(2,0).
- N=4, MCW=5, Cost=W+J -> all 24 assignments total 12: MinCost=12, MatchCount=24. Rerun with MCW=4 -> MatchCount saturates at 15.
- N=8, Cost=7 everywhere except Cost(3,5)=0 and Cost(5,3)=0 -> MinCost=42, MatchCount=720, Valid in cycle 403199.
- Second start after DONE with a different cost table -> results fully re-initialised, no carry-over from the first run. start pulsed mid-run -> ignored, same results and timing.
- RST asserted between clock edges in cycle 100 of a run -> all outputs at reset values immediately. A later start completes normally.
- JAM_PRUNE_EN defined, tables of the previous scenarios -> identical MinCost/MatchCount. Valid cycle strictly earlier for the N=8 table.
